// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared state encoding, ALU function codes and defaults for the MDU/ALU arbiter
package mdu_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int MAX_CYCLES_DEF = 40;
  localparam int CNT_W          = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    WB   = 2'd3
  } mdu_state_t;

  localparam logic [2:0] ALU_F_AND = 3'b000;
  localparam logic [2:0] ALU_F_OR  = 3'b001;
  localparam logic [2:0] ALU_F_ADD = 3'b010;
  localparam logic [2:0] ALU_F_SUB = 3'b110;
  localparam logic [2:0] ALU_F_SLT = 3'b111;

  // The multiplier owns the shared ALU in every state except IDLE.
  function automatic logic mul_owns_alu(input mdu_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/mdu_alu_mux.sv
// rtl/mdu_alu_mux.sv - shared ALU operand/function select between EX and the multiplier
module mdu_alu_mux
  import mdu_pkg::*;
#(
  parameter int         WIDTH   = WIDTH_DEF,
  parameter logic [2:0] ALU_ADD = ALU_F_ADD
) (
  input  logic             mul_own,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  input  logic [2:0]       ex_f,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f
);

  always_comb begin
    alu_a = ex_a;
    alu_b = ex_b;
    alu_f = ex_f;
    if (mul_own) begin
      alu_a = mul_a;
      alu_b = mul_b;
      alu_f = ALU_ADD;
    end
  end

endmodule

// File: rtl/mdu_alu_arbiter.sv
// rtl/mdu_alu_arbiter.sv - MULT/MULTU sequencer sharing the EX ALU with the shift-add multiplier; MDU_WDOG_EN adds a RUN watchdog
module mdu_alu_arbiter
  import mdu_pkg::*;
#(
  parameter int         WIDTH      = WIDTH_DEF,
  parameter int         MAX_CYCLES = MAX_CYCLES_DEF,
  parameter logic [2:0] ALU_ADD    = ALU_F_ADD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MultE,
  input  logic             MultSgn,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             AluReqE,
  input  logic [WIDTH-1:0] ExA,
  input  logic [WIDTH-1:0] ExB,
  input  logic [2:0]       ExF,
  input  logic             HiLoRdE,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] mul_A,
  input  logic [WIDTH-1:0] mul_B,
  output logic             mul_clr,
  output logic             mul_go,
  output logic             mul_sgn,
  output logic [WIDTH-1:0] mul_opA,
  output logic [WIDTH-1:0] mul_opB,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic             mul_done,
  output logic             StallE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             wdog_err
);

  mdu_state_t state;

  if (MAX_CYCLES < 1 || MAX_CYCLES > (1 << CNT_W)) begin : g_bad_max_cycles
    $error("mdu_alu_arbiter: MAX_CYCLES does not fit the RUN counter");
  end

  assign busy   = (state != IDLE);
  // A MULT arriving while idle leaves EX immediately; anything needing ALU or HI/LO waits.
  assign StallE = busy & (AluReqE | MultE | HiLoRdE);

  mdu_alu_mux #(
    .WIDTH   (WIDTH),
    .ALU_ADD (ALU_ADD)
  ) u_alu_mux (
    .mul_own (mul_owns_alu(state)),
    .ex_a    (ExA),
    .ex_b    (ExB),
    .ex_f    (ExF),
    .mul_a   (mul_A),
    .mul_b   (mul_B),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_f   (alu_f)
  );

`ifdef MDU_WDOG_EN
  logic [CNT_W-1:0] run_cnt;
  logic             wdog_q;
  logic             wdog_hit;

  assign wdog_hit = (run_cnt == CNT_W'(MAX_CYCLES - 1));
  assign wdog_err = wdog_q;
`else
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      mul_clr <= 1'b0;
      mul_go  <= 1'b0;
      mul_sgn <= 1'b0;
      mul_opA <= '0;
      mul_opB <= '0;
`ifdef MDU_WDOG_EN
      run_cnt <= '0;
      wdog_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (MultE) begin
            mul_opA <= SrcAE;
            mul_opB <= SrcBE;
            mul_sgn <= MultSgn;
            mul_clr <= 1'b1;
            state   <= CLR;
          end
        end
        CLR: begin
          mul_clr <= 1'b0;
          mul_go  <= 1'b1;
          state   <= RUN;
`ifdef MDU_WDOG_EN
          run_cnt <= '0;
`endif
        end
        RUN: begin
          if (mul_done) begin
            hi     <= mul_hi;
            lo     <= mul_lo;
            mul_go <= 1'b0;
            state  <= WB;
          end
`ifdef MDU_WDOG_EN
          // A hung multiplier commits zeros rather than a partial product.
          else if (wdog_hit) begin
            wdog_q <= 1'b1;
            hi     <= '0;
            lo     <= '0;
            mul_go <= 1'b0;
            state  <= WB;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_alu_arbiter.sv
// tb/tb_mdu_alu_arbiter.sv - bench with shared ALU, shift-add multiplier and arbiter; checks products and stalls
module tb_mdu_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         MultE = 1'b0, MultSgn = 1'b0, AluReqE = 1'b0, HiLoRdE = 1'b0;
  logic [W-1:0] SrcAE = '0, SrcBE = '0, ExA = '0, ExB = '0;
  logic [2:0]   ExF = 3'b000;
  logic [W-1:0] alu_a, alu_b, mul_A, mul_B, mul_opA, mul_opB, mul_hi, mul_lo, hi, lo;
  logic [2:0]   alu_f;
  logic         mul_clr, mul_go, mul_sgn, mul_done, StallE, busy, wdog_err;

  int checks = 0;
  int errors = 0;
  int done_mode = 0;

  always #5 clk = ~clk;

  mdu_alu_arbiter dut (
    .clk(clk), .rst(rst), .MultE(MultE), .MultSgn(MultSgn), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .AluReqE(AluReqE), .ExA(ExA), .ExB(ExB), .ExF(ExF), .HiLoRdE(HiLoRdE),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .mul_A(mul_A), .mul_B(mul_B),
    .mul_clr(mul_clr), .mul_go(mul_go), .mul_sgn(mul_sgn), .mul_opA(mul_opA), .mul_opB(mul_opB),
    .mul_hi(mul_hi), .mul_lo(mul_lo), .mul_done(mul_done), .StallE(StallE),
    .hi(hi), .lo(lo), .busy(busy), .wdog_err(wdog_err)
  );

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] xa, xb;
    xa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    xb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  // Shared ALU with carry-out so the multiplier can accumulate through it.
  logic [W:0] alu_full;
  always_comb begin
    case (alu_f)
      3'b000:  alu_full = {1'b0, alu_a & alu_b};
      3'b001:  alu_full = {1'b0, alu_a | alu_b};
      3'b010:  alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110:  alu_full = {1'b0, alu_a} - {1'b0, alu_b};
      3'b111:  alu_full = {32'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_full = '0;
    endcase
  end

  // Iterative shift-add multiplier on magnitudes; cleared only by mul_clr.
  logic [W-1:0]   m_hi = '0, m_lo = '0;
  logic [5:0]     m_cnt = '0;
  logic           m_done = 1'b0;
  logic [W-1:0]   mag_a, mag_b;
  logic           m_neg;
  logic [2*W-1:0] m_prod, direct_prod;

  assign mag_a       = (mul_sgn && mul_opA[W-1]) ? -mul_opA : mul_opA;
  assign mag_b       = (mul_sgn && mul_opB[W-1]) ? -mul_opB : mul_opB;
  assign m_neg       = mul_sgn & (mul_opA[W-1] ^ mul_opB[W-1]);
  assign m_prod      = m_neg ? -{m_hi, m_lo} : {m_hi, m_lo};
  assign direct_prod = ref_prod(mul_opA, mul_opB, mul_sgn);
  assign mul_A       = m_hi;
  assign mul_B       = m_lo[0] ? mag_a : '0;
  assign mul_done    = (done_mode == 1) ? 1'b0 : (done_mode == 2) ? 1'b1 : m_done;
  assign mul_hi      = (done_mode == 2) ? direct_prod[63:32] : m_prod[63:32];
  assign mul_lo      = (done_mode == 2) ? direct_prod[31:0]  : m_prod[31:0];

  always @(posedge clk) begin
    if (mul_clr) begin
      m_hi   <= '0;
      m_lo   <= mag_b;
      m_cnt  <= '0;
      m_done <= 1'b0;
    end else if (mul_go && m_cnt < 6'd32) begin
      {m_hi, m_lo} <= {alu_full, m_lo[W-1:1]};
      m_cnt        <= m_cnt + 6'd1;
      if (m_cnt == 6'd31) m_done <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one MULT from IDLE and waits for the unit to return to IDLE.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int n, output logic stall_seen);
    @(negedge clk);
    SrcAE = a; SrcBE = b; MultSgn = sgn; MultE = 1'b1;
    #1 chk("accept_no_stall", StallE, 0);
    @(negedge clk);
    MultE = 1'b0; SrcAE = $urandom; SrcBE = $urandom; MultSgn = ~sgn;
    #1;
    n = 0; stall_seen = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      if (n == 1) begin
        chk("clr_pulse", {mul_clr, mul_go}, 2'b10);
        chk("latch_a", mul_opA, a);
        chk("latch_b", mul_opB, b);
        chk("latch_sgn", mul_sgn, sgn);
      end
      if (n == 2) chk("run_go", {mul_clr, mul_go}, 2'b01);
      if (StallE !== 1'b0) stall_seen = 1'b1;
      @(negedge clk); #1;
    end
    if (n >= 300) chk("mult_timeout", busy, 0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    int          mode;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_n;
  } vec_t;

  vec_t        vecs[8];
  int          n;
  logic        st, bad;
  logic [31:0] ra, rb;
  logic        rs;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{32'd51,        32'd51,        1'b0, 0, 32'h0000_0000, 32'd2601,      35};
    vecs[1] = '{32'hFFFF_FFFD, 32'd5,         1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 35};
    vecs[2] = '{32'd7,         32'd9,         1'b0, 2, 32'h0000_0000, 32'd63,        3};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'hFFFF_FFFE, 32'h0000_0001, 35};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 0, 32'h4000_0000, 32'h0000_0000, 35};
    vecs[5] = '{32'hFFFF_FFFF, 32'd1,         1'b1, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3};
    vecs[6] = '{32'd0,         32'hDEAD_BEEF, 1'b1, 0, 32'h0000_0000, 32'h0000_0000, 35};
    vecs[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 32'hC000_0000, 32'h8000_0000, 35};

    #2 rst = 1'b0;
    #1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_ctrl", {busy, mul_clr, mul_go, mul_sgn, wdog_err, StallE}, 6'b0);
    chk("rst_ops", {mul_opA, mul_opB}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // IDLE: EX owns the ALU combinationally and is never stalled.
    @(negedge clk);
    ExA = 32'h1357_9BDF; ExB = 32'h0246_8ACE; ExF = 3'b110; AluReqE = 1'b1;
    #1;
    chk("idle_alu_ops", {alu_a, alu_b}, {32'h1357_9BDF, 32'h0246_8ACE});
    chk("idle_alu_f", alu_f, 3'b110);
    chk("idle_no_stall", StallE, 0);
    AluReqE = 1'b0;

    for (int i = 0; i < 8; i++) begin
      done_mode = vecs[i].mode;
      do_mult(vecs[i].a, vecs[i].b, vecs[i].sgn, n, st);
      chk($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      chk($sformatf("vec%0d_latency", i), n, vecs[i].exp_n);
      chk($sformatf("vec%0d_no_stall", i), st, 0);
    end
    done_mode = 0;

    // EX add while the multiplier owns the ALU.
    @(negedge clk);
    SrcAE = 32'd1000; SrcBE = 32'd1000; MultSgn = 1'b0; MultE = 1'b1;
    @(negedge clk);
    MultE = 1'b0;
    @(negedge clk);
    AluReqE = 1'b1; ExA = 32'd100; ExB = 32'd23; ExF = 3'b010;
    #1;
    chk("run_stall", StallE, 1);
    chk("run_alu_f", alu_f, 3'b010);
    chk("run_alu_ops", {alu_a, alu_b}, {mul_A, mul_B});
    n = 0; bad = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      if (StallE !== 1'b1) bad = 1'b1;
      n++;
      @(negedge clk); #1;
    end
    chk("run_stall_held", bad, 0);
    chk("ex_add_first_idle", {StallE, alu_full}, {1'b0, 33'd123});
    chk("shared_prod", {hi, lo}, 64'd1000000);
    AluReqE = 1'b0;

    // MFHI right behind a MULT must wait for the new HI.
    do_mult(32'hFFFF_FFFF, 32'd2, 1'b0, n, st);
    chk("mfhi_prior", {hi, lo}, 64'h1_FFFF_FFFE);
    @(negedge clk);
    SrcAE = 32'h4000_0000; SrcBE = 32'h10; MultSgn = 1'b0; MultE = 1'b1;
    @(negedge clk);
    MultE = 1'b0; HiLoRdE = 1'b1;
    #1;
    n = 0;
    while (StallE === 1'b1 && n < 300) begin
      n++;
      @(negedge clk); #1;
    end
    chk("mfhi_stall_len", n, 35);
    chk("mfhi_value", {busy, hi}, {1'b0, 32'd4});
    HiLoRdE = 1'b0;

    // Back-to-back MULT: second one holds in EX until IDLE, then goes the same cycle.
    @(negedge clk);
    SrcAE = 32'd11; SrcBE = 32'd13; MultSgn = 1'b0; MultE = 1'b1;
    #1 chk("b2b_first_accept", StallE, 0);
    @(negedge clk);
    SrcAE = 32'hFFFF_FFF9; SrcBE = 32'd6; MultSgn = 1'b1;
    #1;
    n = 0; bad = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      if (StallE !== 1'b1) bad = 1'b1;
      n++;
      @(negedge clk); #1;
    end
    chk("b2b_stalled", bad, 0);
    chk("b2b_first_result", {hi, lo}, 64'd143);
    chk("b2b_second_accept", StallE, 0);
    @(negedge clk);
    MultE = 1'b0;
    #1 chk("b2b_second_busy", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clk); #1;
    end
    chk("b2b_second_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    SrcAE = 32'h1234; SrcBE = 32'h5678; MultSgn = 1'b0; MultE = 1'b1;
    @(negedge clk);
    MultE = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrun_rst_busy", {busy, mul_go, mul_clr}, 3'b000);
    chk("midrun_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_mult(32'd7, 32'd9, 1'b0, n, st);
    chk("after_rst_7x9", {hi, lo}, 64'd63);
    chk("after_rst_latency", n, 35);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'd0;
        default: ;
      endcase
      done_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      do_mult(ra, rb, rs, n, st);
      chk($sformatf("rand%0d_a%h_b%h_s%0d", i, ra, rb, rs), {hi, lo}, ref_prod(ra, rb, rs));
    end
    done_mode = 0;

    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n, st);
    chk("pre_hang_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    done_mode = 1;
`ifdef MDU_WDOG_EN
    do_mult(32'd5, 32'd5, 1'b0, n, st);
    chk("wdog_latency", n, 42);
    chk("wdog_err_set", {wdog_err, busy}, 2'b10);
    chk("wdog_hilo_zero", {hi, lo}, 64'd0);
    repeat (3) @(negedge clk);
    #1 chk("wdog_sticky", wdog_err, 1);
`else
    @(negedge clk);
    SrcAE = 32'd5; SrcBE = 32'd5; MultSgn = 1'b0; MultE = 1'b1;
    @(negedge clk);
    MultE = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    chk("hang_busy", {busy, wdog_err}, 2'b10);
    chk("hang_no_commit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
`endif
    done_mode = 0;
    #2 rst = 1'b0;
    #1 chk("final_rst", {busy, wdog_err}, 2'b00);
    @(negedge clk);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
